compare_stats_collector: RTL and testbench
==========================================

# compare_stats_collector

Downstream consumer of the 3-bit magnitude comparator's `A_greater`/`A_equal`/`A_less` flags. It accepts one flag triple per valid/ready handshake and keeps per-window statistics:
- saturating counts of greater, equal and less results;
- the longest run of consecutive equal results.

On request, it freezes the window into a snapshot, presents it on a valid/ready output, and starts a fresh window.

## Interface
- `CNT_W`, default 8: width of every counter and snapshot field.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous clear; highest priority
- `in_valid`  in  1  flag triple valid
- `in_ready`  out  1  collector can accept a sample
- `A_greater`  in  1  comparator flag, A>B
- `A_equal`  in  1  comparator flag, A==B
- `A_less`  in  1  comparator flag, A<B
- `snap_req`  in  1  single-cycle snapshot request
- `out_valid`  out  1  snapshot fields valid
- `out_ready`  in  1  downstream takes the snapshot
- `gt_cnt`  out  CNT_W  snapshot greater count
- `eq_cnt`  out  CNT_W  snapshot equal count
- `lt_cnt`  out  CNT_W  snapshot less count
- `max_eq_run`  out  CNT_W  snapshot longest equal run
- `err`  out  1  sticky malformed-input flag; only present with `COMPARE_ONEHOT_CHECK_EN`

## Operation
- Two-state FSM: ACCUM and HOLD. Reset state is ACCUM.
- `in_ready` = (state == ACCUM). A sample is accepted when `in_valid && in_ready`.
- Classification of an accepted sample:
  - Greater: increments `gt` and zeroes `cur_run`.
  - Less: increments `lt` and zeroes `cur_run`.
  - Equal: increments `eq`, sets `cur_run <= cur_run+1`, sets `max_run <= max(max_run, cur_run+1)`.
- All counters, including `cur_run` and `max_run`, saturate at 2^CNT_W−1. They never wrap.
- `snap_req` in ACCUM:
  - Snapshot registers load the window values, including any sample accepted in the same cycle.
  - Window counters, `cur_run` and `max_run` are zeroed.
  - FSM moves to HOLD.
- `snap_req` in HOLD is ignored and not queued.
- HOLD:
  - `out_valid` = 1; the snapshot fields are stable.
  - No samples are accepted.
  - On `out_valid && out_ready`, the FSM returns to ACCUM.
- `clear`:
  - Zeroes all window counters, `cur_run` and `max_run`.
  - Forces ACCUM and drops `out_valid`.
  - Overrides any simultaneous sample or `snap_req`.
  - Snapshot field values are left unchanged, but they are meaningless while `out_valid` = 0.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - All snapshot fields 0, all counters 0, `err` = 0.

## Timing
- Sample accepted at edge T is included in any snapshot captured at edge T or later.
- `snap_req` sampled high at edge T (state ACCUM): `out_valid` = 1 and `in_ready` = 0 from T+1.
- Handshake completes at edge T+k: `out_valid` = 0 and `in_ready` = 1 from T+k+1. Minimum HOLD length is 1 cycle (`out_ready` already high).
- Outputs are all registered or decoded from FSM state only; there are no combinational paths from inputs.
- Asynchronous reset mid-HOLD: the pending snapshot is discarded and the block returns immediately to the reset values.

## Configuration
- `COMPARE_ONEHOT_CHECK_EN` defined:
  - A malformed accepted sample (anything other than exactly one flag high) counts nowhere and zeroes `cur_run`.
  - It sets sticky `err`, which only reset or `clear` clears.
- Not defined:
  - No `err` port.
  - Flags decode by priority: greater, then less, then equal.
  - An all-zero sample counts as equal.

## Test plan
- Reset, then accept G,E,E,E,L,E,E, then `snap_req`. Expected: `gt_cnt`=1, `eq_cnt`=5, `lt_cnt`=1, `max_eq_run`=3, and `out_valid` high the next cycle.
- Sample and `snap_req` in the same cycle (E). Expected: the snapshot includes it (`eq_cnt`=1). The next window starts at 0, and `in_ready` = 0 until `out_ready`.
- CNT_W=4, 20 consecutive E. Expected: `eq_cnt`=15 and `max_eq_run`=15, both saturated.
- HOLD with `out_ready`=0 for 5 cycles. Expected:
  - fields stable;
  - `in_valid` ignored;
  - a second `snap_req` ignored;
  - `out_ready`=1, then ACCUM with fresh zero counts.
- `clear` asserted during HOLD, together with `in_valid`. Expected: `out_valid` = 0 next cycle, counters 0, and the sample is not counted.
- With `COMPARE_ONEHOT_CHECK_EN`, accept E,E,{G+L},E, then snap. Expected: `eq_cnt`=3, `max_eq_run`=2, `gt_cnt`=0, and `err` = 1 until `clear`.

Source files
------------

// File: rtl/compare_stats_collector.sv
// rtl/compare_stats_collector.sv - windowed comparator-flag statistics with valid/ready snapshot output
// Define COMPARE_ONEHOT_CHECK_EN to reject malformed flag triples and expose the sticky err flag.
module compare_stats_collector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             A_greater,
    input  logic             A_equal,
    input  logic             A_less,
    input  logic             snap_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] max_eq_run
`ifdef COMPARE_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] gt, eq, lt, cur_run, max_run;
    logic [CNT_W-1:0] gt_n, eq_n, lt_n, cur_n, max_n, cur_inc;
    logic             accept, is_gt, is_lt, is_eq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (snap_req) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    assign accept = in_valid && (state == ACCUM);

`ifdef COMPARE_ONEHOT_CHECK_EN
    // Exactly one flag must be high; anything else lands in no bucket.
    assign is_gt = A_greater && !A_equal && !A_less;
    assign is_lt = A_less && !A_greater && !A_equal;
    assign is_eq = A_equal && !A_greater && !A_less;
`else
    // Priority decode: greater, then less, otherwise equal (all-zero counts as equal).
    assign is_gt = A_greater;
    assign is_lt = !A_greater && A_less;
    assign is_eq = !A_greater && !A_less;
`endif

    assign cur_inc = sat_inc(cur_run);

    always_comb begin
        gt_n  = gt;
        eq_n  = eq;
        lt_n  = lt;
        cur_n = cur_run;
        max_n = max_run;
        if (accept) begin
            if (is_gt) begin
                gt_n  = sat_inc(gt);
                cur_n = '0;
            end else if (is_lt) begin
                lt_n  = sat_inc(lt);
                cur_n = '0;
            end else if (is_eq) begin
                eq_n  = sat_inc(eq);
                cur_n = cur_inc;
                max_n = (cur_inc > max_run) ? cur_inc : max_run;
            end else begin
                cur_n = '0;
            end
        end
    end

    // The snapshot takes the *_n values so a sample accepted with snap_req is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt         <= '0;
            eq         <= '0;
            lt         <= '0;
            cur_run    <= '0;
            max_run    <= '0;
            gt_cnt     <= '0;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            max_eq_run <= '0;
        end else if (clear) begin
            gt      <= '0;
            eq      <= '0;
            lt      <= '0;
            cur_run <= '0;
            max_run <= '0;
        end else if (state == ACCUM && snap_req) begin
            gt_cnt     <= gt_n;
            eq_cnt     <= eq_n;
            lt_cnt     <= lt_n;
            max_eq_run <= max_n;
            gt         <= '0;
            eq         <= '0;
            lt         <= '0;
            cur_run    <= '0;
            max_run    <= '0;
        end else begin
            gt      <= gt_n;
            eq      <= eq_n;
            lt      <= lt_n;
            cur_run <= cur_n;
            max_run <= max_n;
        end
    end

`ifdef COMPARE_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err <= 1'b0;
        else if (clear)                         err <= 1'b0;
        else if (accept && !(is_gt || is_lt || is_eq)) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_compare_stats_collector.sv
// tb/tb_compare_stats_collector.sv - scoreboard bench for compare_stats_collector (CNT_W=4)
module tb_compare_stats_collector;

    localparam int CW   = 4;
    localparam int MAXV = (1 << CW) - 1;
    localparam logic [2:0] FG = 3'b100;
    localparam logic [2:0] FE = 3'b010;
    localparam logic [2:0] FL = 3'b001;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic          A_greater, A_equal, A_less;
    logic          snap_req, out_valid, out_ready;
    logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt, max_eq_run;
`ifdef COMPARE_ONEHOT_CHECK_EN
    logic          err;
`endif

    compare_stats_collector #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_greater(A_greater), .A_equal(A_equal), .A_less(A_less),
        .snap_req(snap_req), .out_valid(out_valid), .out_ready(out_ready),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .max_eq_run(max_eq_run)
`ifdef COMPARE_ONEHOT_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int e;
        int l;
        int r;
    } snap_t;

    snap_t sb[$];
    int    win[$];       // classes of samples in the current window: 0 gt, 1 eq, 2 lt, 3 malformed
    bit    exp_hold = 1'b0;
    bit    exp_err  = 1'b0;
    bit    prev_ov  = 1'b0;
    snap_t last;
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [2:0] f);
`ifdef COMPARE_ONEHOT_CHECK_EN
        if (int'(f[2]) + int'(f[1]) + int'(f[0]) != 1) return 3;
        return f[2] ? 0 : (f[0] ? 2 : 1);
`else
        return f[2] ? 0 : (f[0] ? 2 : 1);
`endif
    endfunction

    function automatic int cap(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic snap_t window_stats();
        snap_t s;
        int run, best;
        s = '{0, 0, 0, 0};
        run = 0;
        best = 0;
        foreach (win[i]) begin
            if (win[i] == 0) s.g++;
            if (win[i] == 2) s.l++;
            if (win[i] == 1) begin
                s.e++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        s.g = cap(s.g);
        s.e = cap(s.e);
        s.l = cap(s.l);
        s.r = cap(best);
        return s;
    endfunction

    // Drive one cycle of inputs and advance the reference model to the state after the next edge.
    task automatic step(input bit iv, input logic [2:0] f, input bit sn, input bit ordy, input bit clr);
        @(negedge clk);
        in_valid  = iv;
        A_greater = f[2];
        A_equal   = f[1];
        A_less    = f[0];
        snap_req  = sn;
        out_ready = ordy;
        clear     = clr;
        if (clr) begin
            win.delete();
            exp_hold = 1'b0;
            exp_err  = 1'b0;
        end else if (!exp_hold) begin
            if (iv) begin
                win.push_back(classify(f));
                if (classify(f) == 3) exp_err = 1'b1;
            end
            if (sn) begin
                sb.push_back(window_stats());
                win.delete();
                exp_hold = 1'b1;
            end
        end else if (ordy) begin
            exp_hold = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, ordy, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            chk("out_valid", int'(out_valid), int'(exp_hold));
            chk("in_ready", int'(in_ready), int'(!exp_hold));
`ifdef COMPARE_ONEHOT_CHECK_EN
            chk("err", int'(err), int'(exp_err));
`endif
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_snapshot", 1, 0);
                end else begin
                    last = sb.pop_front();
                    chk("gt_cnt", int'(gt_cnt), last.g);
                    chk("eq_cnt", int'(eq_cnt), last.e);
                    chk("lt_cnt", int'(lt_cnt), last.l);
                    chk("max_eq_run", int'(max_eq_run), last.r);
                end
            end else if (out_valid) begin
                chk("gt_cnt_hold", int'(gt_cnt), last.g);
                chk("eq_cnt_hold", int'(eq_cnt), last.e);
                chk("lt_cnt_hold", int'(lt_cnt), last.l);
                chk("max_eq_run_hold", int'(max_eq_run), last.r);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [2:0] f;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
        A_greater = 1'b0; A_equal = 1'b0; A_less = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_gt_cnt", int'(gt_cnt), 0);
        chk("rst_eq_cnt", int'(eq_cnt), 0);
        chk("rst_lt_cnt", int'(lt_cnt), 0);
        chk("rst_max_eq_run", int'(max_eq_run), 0);
`ifdef COMPARE_ONEHOT_CHECK_EN
        chk("rst_err", int'(err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // G,E,E,E,L,E,E then snapshot: 1/5/1 with longest equal run 3
        step(1, FG, 0, 0, 0);
        repeat (3) step(1, FE, 0, 0, 0);
        step(1, FL, 0, 0, 0);
        repeat (2) step(1, FE, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        step(0, 3'b000, 0, 1, 0);

        // Sample in the snapshot cycle is included; next window is empty
        step(1, FE, 1, 0, 0);
        idle(2, 0);
        step(0, 3'b000, 0, 1, 0);
        step(0, 3'b000, 1, 1, 0);
        step(0, 3'b000, 0, 1, 0);

        // Saturation at 15
        repeat (20) step(1, FE, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        step(0, 3'b000, 0, 1, 0);

        // Long HOLD: samples and a second snap_req are ignored
        step(1, FG, 0, 0, 0);
        step(1, FE, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, (i % 2) ? FG : FE, (i == 2), 0, 0);
        step(0, 3'b000, 0, 1, 0);
        step(0, 3'b000, 1, 1, 0);
        step(0, 3'b000, 0, 1, 0);

        // clear during HOLD together with a sample
        step(1, FL, 1, 0, 0);
        step(1, FE, 0, 0, 0);
        step(1, FG, 0, 0, 1);
        step(1, FE, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        step(0, 3'b000, 0, 1, 0);

        // E,E,{G+L},E then snapshot
        repeat (2) step(1, FE, 0, 0, 0);
        step(1, 3'b101, 0, 0, 0);
        step(1, FE, 1, 0, 0);
        idle(2, 0);
        step(0, 3'b000, 0, 1, 0);
        idle(2, 0);
        step(0, 3'b000, 0, 0, 1);
        idle(1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 3))
                    0: f = FG;
                    1: f = FL;
                    default: f = FE;
                endcase
            end else begin
                f = 3'($urandom_range(0, 7));
            end
            step($urandom_range(0, 9) < 8, f, $urandom_range(0, 99) < ((i < 300) ? 8 : 3),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        idle(3, 1);

        // Asynchronous reset while a snapshot is pending
        repeat (5) step(1, FE, 0, 0, 0);
        step(1, FG, 1, 0, 0);
        @(posedge clk);
        #3;
        snap_req = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_eq_cnt", int'(eq_cnt), 0);
        chk("mid_rst_max_eq_run", int'(max_eq_run), 0);
        @(negedge clk);
        rst_n = 1'b1;
        win.delete();
        exp_hold = 1'b0;
        exp_err  = 1'b0;
        step(1, FL, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        step(0, 3'b000, 0, 1, 0);
        idle(2, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
